// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
// The header packs the payload length above the destination address.
package router_pkg;

  localparam int HDR_ADDR_W = 2;
  localparam int HDR_LEN_W  = 6;
  localparam int MAX_PAYLOAD = 63;
  localparam int DATA_W     = 8;
  localparam int BUF_DEPTH  = 64;
  localparam logic [HDR_ADDR_W-1:0] ILLEGAL_ADDR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_HEADER  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_PARITY  = 3'd4,
    ST_GAP     = 3'd5
  } tx_state_t;

  function automatic logic cfg_legal(input logic [HDR_ADDR_W-1:0] addr,
                                     input logic [HDR_LEN_W-1:0]  len);
    return (addr != ILLEGAL_ADDR) && (len != '0);
  endfunction

  function automatic logic [DATA_W-1:0] make_header(input logic [HDR_ADDR_W-1:0] addr,
                                                    input logic [HDR_LEN_W-1:0]  len);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload staging buffer: synchronous write, combinational read.
// The array is never reset; stale contents are always overwritten before use.
module router_tx_buf
  import router_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [HDR_LEN_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [HDR_LEN_W-1:0] i_raddr,
  output logic [DATA_W-1:0]    o_rdata
);

  logic [DATA_W-1:0] r_mem [BUF_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a payload, then sends header, payload and an
// XOR parity byte to the router, followed by a fixed idle gap.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [HDR_ADDR_W-1:0] i_dest_addr,
  input  logic [HDR_LEN_W-1:0]  i_pay_len,
  input  logic [DATA_W-1:0]     i_src_data,
  input  logic                  i_src_valid,
  output logic                  o_src_ready,
  input  logic                  i_busy,
  input  logic                  i_err,
  output logic [DATA_W-1:0]     o_data_in,
  output logic                  o_pkt_valid,
  output logic                  o_tx_idle,
  output logic                  o_tx_done,
  output logic                  o_cfg_err,
  output logic                  o_tx_err,
  output logic [2:0]            o_dbg_state
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  tx_state_t             r_state;
  logic [HDR_ADDR_W-1:0] r_addr;
  logic [HDR_LEN_W-1:0]  r_len;
  logic [HDR_LEN_W-1:0]  r_idx;
  logic [DATA_W-1:0]     r_parity;
  logic [DATA_W-1:0]     r_data_in;
  logic                  r_pkt_valid;
  logic                  r_src_ready;
  logic                  r_tx_idle;
  logic                  r_tx_done;
  logic                  r_cfg_err;
  logic                  r_tx_err;
  logic [GAP_W-1:0]      r_gap_cnt;

  logic                  w_src_xfer;
  logic                  w_last_idx;
  logic [HDR_LEN_W-1:0]  w_rd_addr;
  logic [DATA_W-1:0]     w_rd_data;

  // Handshakes: a source byte moves on a posedge with i_src_valid & o_src_ready;
  // the byte on o_data_in moves to the router on a posedge with i_busy low.
  assign w_src_xfer = i_src_valid & r_src_ready;
  assign w_last_idx = (r_idx == r_len - 6'd1);

  // Read one byte ahead so the next payload byte is ready at the accepting edge.
  assign w_rd_addr = (r_state == ST_PAYLOAD) ? r_idx + 6'd1 : '0;

  router_tx_buf u_buf (
    .i_clk   (i_clock),
    .i_we    (w_src_xfer),
    .i_waddr (r_idx),
    .i_wdata (i_src_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_parity    <= '0;
      r_data_in   <= '0;
      r_pkt_valid <= 1'b0;
      r_src_ready <= 1'b0;
      r_tx_idle   <= 1'b1;
      r_tx_done   <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_tx_err    <= 1'b0;
      r_gap_cnt   <= '0;
    end else begin
      r_tx_done <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (cfg_legal(i_dest_addr, i_pay_len)) begin
              r_addr      <= i_dest_addr;
              r_len       <= i_pay_len;
              r_idx       <= '0;
              r_tx_err    <= 1'b0;
              r_src_ready <= 1'b1;
              r_tx_idle   <= 1'b0;
              r_state     <= ST_LOAD;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (w_src_xfer) begin
            r_idx <= r_idx + 6'd1;
            if (w_last_idx) begin
              r_src_ready <= 1'b0;
              r_data_in   <= make_header(r_addr, r_len);
              r_parity    <= make_header(r_addr, r_len);
              r_pkt_valid <= 1'b1;
              r_state     <= ST_HEADER;
            end
          end
        end
        ST_HEADER: begin
          if (!i_busy) begin
            r_idx     <= '0;
            r_data_in <= w_rd_data;
            r_state   <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (!i_busy) begin
            r_parity <= r_parity ^ r_data_in;
            if (w_last_idx) begin
              r_data_in   <= r_parity ^ r_data_in;
              r_pkt_valid <= 1'b0;
              r_state     <= ST_PARITY;
            end else begin
              r_idx     <= r_idx + 6'd1;
              r_data_in <= w_rd_data;
            end
          end
        end
        ST_PARITY: begin
          if (!i_busy) begin
            r_tx_done <= 1'b1;
            r_data_in <= '0;
            r_gap_cnt <= '0;
            r_state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (i_err) begin
            r_tx_err <= 1'b1;
          end
          if (r_gap_cnt == GAP_LAST) begin
            r_tx_idle <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_pkt_valid <= 1'b0;
          r_src_ready <= 1'b0;
          r_data_in   <= '0;
          r_tx_idle   <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_src_ready = r_src_ready;
  assign o_data_in   = r_data_in;
  assign o_pkt_valid = r_pkt_valid;
  assign o_tx_idle   = r_tx_idle;
  assign o_tx_done   = r_tx_done;
  assign o_cfg_err   = r_cfg_err;
  assign o_tx_err    = r_tx_err;
  assign o_dbg_state = r_state;

endmodule
